// File: rtl/alarm_clock_pkg.sv
// Shared types and limits for the alarm clock time-entry path.
// Holds the entry FSM state enum, the default timeout and the BCD digit limits.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    SHOW_ALARM
  } entry_state_t;

  localparam int DEFAULT_TIMEOUT_S = 10;

  localparam logic [3:0] MAX_MS_HR      = 4'd2;
  localparam logic [3:0] MAX_LS_HR_AT_2 = 4'd3;
  localparam logic [3:0] MAX_MS_MIN     = 4'd5;
  localparam logic [3:0] MAX_BCD        = 4'd9;

  function automatic logic bcd_ok(input logic [3:0] d);
    return d <= MAX_BCD;
  endfunction

endpackage

// File: rtl/key_shift_reg.sv
// Four-digit HH:MM entry shift register with clear/shift and time validity check.
// Ports: clk, reset, clr, shift, key in; ms_hr/ls_hr/ms_min/ls_min, valid out.
module key_shift_reg
  import alarm_clock_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       shift,
  input  logic [3:0] key,
  output logic [3:0] ms_hr,
  output logic [3:0] ls_hr,
  output logic [3:0] ms_min,
  output logic [3:0] ls_min,
  output logic       valid
);

  // clr only matters together with shift: a fresh entry
  // starts as 0,0,0,key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_hr  <= '0;
      ls_hr  <= '0;
      ms_min <= '0;
      ls_min <= '0;
    end else if (shift) begin
      if (clr) begin
        ms_hr  <= '0;
        ls_hr  <= '0;
        ms_min <= '0;
      end else begin
        ms_hr  <= ls_hr;
        ls_hr  <= ms_min;
        ms_min <= ls_min;
      end
      ls_min <= key;
    end
  end

  logic hr_ok;
  logic min_ok;

  assign hr_ok = (ms_hr <= MAX_MS_HR)
              && bcd_ok(ls_hr)
              && ((ms_hr != MAX_MS_HR)
                  || (ls_hr <= MAX_LS_HR_AT_2));

  assign min_ok = (ms_min <= MAX_MS_MIN)
               && bcd_ok(ls_min);

  assign valid = hr_ok && min_ok;

endmodule

// File: rtl/time_entry_ctrl.sv
// Keypad time-entry controller: collects HH:MM, validates, strobes loads.
// Ports: clk, reset, one_second, key/key_valid, buttons in; digits, strobes, show flags out.
module time_entry_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int TIMEOUT_S = DEFAULT_TIMEOUT_S
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       key_valid,
  input  logic       time_button,
  input  logic       alarm_button,
  output logic [3:0] new_time_ms_hr,
  output logic [3:0] new_time_ls_hr,
  output logic [3:0] new_time_ms_min,
  output logic [3:0] new_time_ls_min,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       reset_count,
  output logic       show_new_time,
  output logic       show_alarm,
  output logic       entry_error
);

  localparam int CW = $clog2(TIMEOUT_S + 1);
  localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT_S);

  entry_state_t state;

  logic          time_q;
  logic          alarm_q;
  logic [CW-1:0] tcnt;
  logic [CW-1:0] tcnt_inc;

  logic key_acc;
  logic time_rise;
  logic alarm_rise;
  logic commit;
  logic clr;
  logic shift;
  logic valid;

  assign key_acc    = key_valid && bcd_ok(key);
  assign time_rise  = time_button && !time_q;
  assign alarm_rise = alarm_button && !alarm_q;
  assign commit     = time_rise || alarm_rise;

  // A button edge in ENTRY swallows a coincident key.
  assign clr   = (state == IDLE);
  assign shift = key_acc
              && ((state == IDLE)
                  || ((state == ENTRY) && !commit));

  assign tcnt_inc = (tcnt >= T_MAX) ? tcnt : tcnt + 1'b1;

  key_shift_reg u_sr (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .shift  (shift),
    .key    (key),
    .ms_hr  (new_time_ms_hr),
    .ls_hr  (new_time_ls_hr),
    .ms_min (new_time_ms_min),
    .ls_min (new_time_ls_min),
    .valid  (valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      time_q        <= 1'b0;
      alarm_q       <= 1'b0;
      tcnt          <= '0;
      load_new_c    <= 1'b0;
      load_new_a    <= 1'b0;
      reset_count   <= 1'b0;
      entry_error   <= 1'b0;
      show_new_time <= 1'b0;
      show_alarm    <= 1'b0;
    end else begin
      time_q      <= time_button;
      alarm_q     <= alarm_button;
      load_new_c  <= 1'b0;
      load_new_a  <= 1'b0;
      reset_count <= 1'b0;
      entry_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (key_acc) begin
            state         <= ENTRY;
            tcnt          <= '0;
            show_new_time <= 1'b1;
          end else if (alarm_button) begin
            state      <= SHOW_ALARM;
            tcnt       <= '0;
            show_alarm <= 1'b1;
          end
        end
        ENTRY: begin
          if (commit) begin
            state         <= IDLE;
            tcnt          <= '0;
            show_new_time <= 1'b0;
            if (!valid) begin
              entry_error <= 1'b1;
            end else if (time_rise) begin
              load_new_c  <= 1'b1;
              reset_count <= 1'b1;
            end else begin
              load_new_a <= 1'b1;
            end
          end else if (key_acc) begin
            tcnt <= '0;
          end else if (one_second) begin
            if (tcnt_inc >= T_MAX) begin
              state         <= IDLE;
              tcnt          <= '0;
              show_new_time <= 1'b0;
            end else begin
              tcnt <= tcnt_inc;
            end
          end
        end
        SHOW_ALARM: begin
          if (!alarm_button) begin
            state      <= IDLE;
            tcnt       <= '0;
            show_alarm <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          tcnt          <= '0;
          show_new_time <= 1'b0;
          show_alarm    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Self-checking bench for time_entry_ctrl.
// Reference model tracks entered keys as a queue and checks every cycle.
module tb_time_entry_ctrl;

  localparam int TMO = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       one_second;
  logic [3:0] key;
  logic       key_valid;
  logic       time_button;
  logic       alarm_button;
  logic [3:0] d_mh, d_lh, d_mm, d_lm;
  logic       load_new_c, load_new_a, reset_count;
  logic       show_new_time, show_alarm, entry_error;

  int checks   = 0;
  int failures = 0;

  time_entry_ctrl #(.TIMEOUT_S(TMO)) dut (
    .clk             (clk),
    .reset           (reset),
    .one_second      (one_second),
    .key             (key),
    .key_valid       (key_valid),
    .time_button     (time_button),
    .alarm_button    (alarm_button),
    .new_time_ms_hr  (d_mh),
    .new_time_ls_hr  (d_lh),
    .new_time_ms_min (d_mm),
    .new_time_ls_min (d_lm),
    .load_new_c      (load_new_c),
    .load_new_a      (load_new_a),
    .reset_count     (reset_count),
    .show_new_time   (show_new_time),
    .show_alarm      (show_alarm),
    .entry_error     (entry_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Model: mode 0=idle 1=entering 2=viewing alarm.
  int  m_mode;
  int  keys[$];
  int  secs;
  bit  tp, ap;
  bit  e_c, e_a, e_e, e_snt, e_sa;
  int  e_d[4];

  function automatic int digit(int i);
    int idx;
    idx = keys.size() - 4 + i;
    return (idx >= 0) ? keys[idx] : 0;
  endfunction

  function automatic bit time_ok();
    int hh, mm;
    hh = digit(0) * 10 + digit(1);
    mm = digit(2) * 10 + digit(3);
    return (hh < 24) && (mm < 60);
  endfunction

  always @(posedge clk or posedge reset) begin
    bit tr, ar, acc;
    if (reset) begin
      m_mode = 0; keys.delete(); secs = 0;
      tp = 0; ap = 0;
      e_c = 0; e_a = 0; e_e = 0; e_snt = 0; e_sa = 0;
    end else begin
      tr  = time_button && !tp;
      ar  = alarm_button && !ap;
      acc = key_valid && (int'(key) <= 9);
      e_c = 0; e_a = 0; e_e = 0;
      if (m_mode == 0) begin
        if (acc) begin
          keys.delete();
          keys.push_back(int'(key));
          secs = 0;
          m_mode = 1;
        end else if (alarm_button) begin
          m_mode = 2;
        end
      end else if (m_mode == 1) begin
        if (tr || ar) begin
          if (!time_ok()) e_e = 1;
          else if (tr) e_c = 1;
          else e_a = 1;
          m_mode = 0;
        end else if (acc) begin
          keys.push_back(int'(key));
          secs = 0;
        end else if (one_second) begin
          secs++;
          if (secs >= TMO) m_mode = 0;
        end
      end else begin
        if (!alarm_button) m_mode = 0;
      end
      tp = time_button;
      ap = alarm_button;
      e_snt = (m_mode == 1);
      e_sa  = (m_mode == 2);
    end
    for (int i = 0; i < 4; i++) e_d[i] = digit(i);
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("ms_hr", d_mh, e_d[0]);
      chk("ls_hr", d_lh, e_d[1]);
      chk("ms_min", d_mm, e_d[2]);
      chk("ls_min", d_lm, e_d[3]);
      chk("load_new_c", load_new_c, e_c);
      chk("load_new_a", load_new_a, e_a);
      chk("reset_count", reset_count, e_c);
      chk("entry_error", entry_error, e_e);
      chk("show_new_time", show_new_time, e_snt);
      chk("show_alarm", show_alarm, e_sa);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key_in(input int k);
    key = 4'(k);
    key_valid = 1'b1;
    cyc(1);
    key_valid = 1'b0;
  endtask

  task automatic keys4(input int a, input int b,
                       input int c, input int d);
    key_in(a); key_in(b); key_in(c); key_in(d);
  endtask

  task automatic sec_pulse();
    one_second = 1'b1;
    cyc(1);
    one_second = 1'b0;
    cyc(1);
  endtask

  task automatic chk_digits(input string n, input int a,
                            input int b, input int c,
                            input int d);
    chk({n, "_d0"}, d_mh, a);
    chk({n, "_d1"}, d_lh, b);
    chk({n, "_d2"}, d_mm, c);
    chk({n, "_d3"}, d_lm, d);
  endtask

  initial begin
    reset = 1'b1;
    one_second = 1'b0;
    key = 4'd0;
    key_valid = 1'b0;
    time_button = 1'b0;
    alarm_button = 1'b0;
    cyc(2);
    chk_digits("rst", 0, 0, 0, 0);
    chk("rst_load_c", load_new_c, 0);
    chk("rst_show", show_new_time, 0);
    reset = 1'b0;
    cyc(2);

    // 1,2,3,4 committed as current time
    keys4(1, 2, 3, 4);
    chk_digits("t1", 1, 2, 3, 4);
    chk("t1_show", show_new_time, 1);
    time_button = 1'b1;
    cyc(1);
    time_button = 1'b0;
    chk("t1_load_c", load_new_c, 1);
    chk("t1_rcount", reset_count, 1);
    cyc(1);
    chk("t1_load_c_off", load_new_c, 0);
    chk("t1_show_off", show_new_time, 0);
    chk_digits("t1b", 1, 2, 3, 4);
    cyc(2);

    // 24:00 rejected, 23:59 loaded as alarm
    keys4(2, 4, 0, 0);
    time_button = 1'b1;
    cyc(1);
    time_button = 1'b0;
    chk("t2_err", entry_error, 1);
    chk("t2_no_load", load_new_c, 0);
    cyc(2);
    keys4(2, 3, 5, 9);
    alarm_button = 1'b1;
    cyc(1);
    alarm_button = 1'b0;
    chk("t2_load_a", load_new_a, 1);
    chk_digits("t2", 2, 3, 5, 9);
    cyc(2);

    // 19:60 and 29:00 rejected
    keys4(1, 9, 6, 0);
    time_button = 1'b1;
    cyc(1);
    time_button = 1'b0;
    chk("t2_1960", entry_error, 1);
    cyc(1);
    keys4(2, 9, 0, 0);
    alarm_button = 1'b1;
    cyc(1);
    alarm_button = 1'b0;
    chk("t2_2900", entry_error, 1);
    cyc(2);

    // ignored key, last four digits win
    key_in(5); key_in(12); keys4(1, 2, 3, 0);
    chk_digits("t3", 1, 2, 3, 0);
    time_button = 1'b1;
    cyc(1);
    time_button = 1'b0;
    chk("t3_load_c", load_new_c, 1);
    cyc(2);

    // button held across entry does not commit
    time_button = 1'b1;
    cyc(2);
    key_in(4);
    cyc(2);
    chk("held_no_load", load_new_c, 0);
    chk("held_show", show_new_time, 1);
    time_button = 1'b0;
    cyc(1);
    time_button = 1'b1;
    cyc(1);
    time_button = 1'b0;
    chk("held_reload", load_new_c, 1);
    chk_digits("held", 0, 0, 0, 4);
    cyc(2);

    // timeout, restarted by a key after the 9th pulse
    key_in(7);
    repeat (9) sec_pulse();
    chk("t4_still", show_new_time, 1);
    key_in(8);
    repeat (9) sec_pulse();
    chk("t4_restart", show_new_time, 1);
    sec_pulse();
    chk("t4_timeout", show_new_time, 0);
    chk_digits("t4", 0, 0, 7, 8);
    cyc(2);

    // both buttons and a key together
    keys4(1, 2, 0, 0);
    key = 4'd5;
    key_valid = 1'b1;
    time_button = 1'b1;
    alarm_button = 1'b1;
    cyc(1);
    key_valid = 1'b0;
    time_button = 1'b0;
    alarm_button = 1'b0;
    chk("t5_load_c", load_new_c, 1);
    chk("t5_no_load_a", load_new_a, 0);
    chk_digits("t5", 1, 2, 0, 0);
    cyc(2);

    // alarm display held in idle
    alarm_button = 1'b1;
    cyc(1);
    chk("t5_show_alarm", show_alarm, 1);
    key_in(3);
    cyc(2);
    chk("t5_alarm_held", show_alarm, 1);
    alarm_button = 1'b0;
    cyc(1);
    chk("t5_alarm_off", show_alarm, 0);
    chk_digits("t5b", 1, 2, 0, 0);
    cyc(2);

    // reset right after a commit edge
    keys4(1, 2, 3, 4);
    time_button = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_pre", load_new_c, 1);
    reset = 1'b1;
    #1;
    chk("t6_load_c", load_new_c, 0);
    chk("t6_rcount", reset_count, 0);
    chk("t6_show", show_new_time, 0);
    chk_digits("t6", 0, 0, 0, 0);
    time_button = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/time_entry_ctrl.md
# time_entry_ctrl

Key-entry controller sitting directly upstream of the current-time counter and alarm register. It collects BCD digits from the keypad into a four-digit HH:MM shift register, validates the entered time, and issues single-cycle `load_new_c` / `load_new_a` strobes together with the four new-time digits. It also drives display-select and timeout behaviour, and pulses `reset_count` so the seconds generator restarts its minute whenever a new current time is loaded.

## Interface
- `TIMEOUT_S`, default 10: number of `one_second` pulses without an accepted key before entry is abandoned.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `one_second` in 1: single-cycle pulse from the seconds generator.
- `key` in 4: BCD digit; values 0–9 accepted, 10–15 ignored.
- `key_valid` in 1: single-cycle strobe qualifying `key`.
- `time_button` in 1: level; commit entry as current time.
- `alarm_button` in 1: level; commit entry as alarm, or show alarm when idle.
- `new_time_ms_hr`, `new_time_ls_hr`, `new_time_ms_min`, `new_time_ls_min` out 4 each: entered digits, driven to the counter and the alarm register.
- `load_new_c` out 1: single-cycle strobe to load the current time.
- `load_new_a` out 1: single-cycle strobe to load the alarm time.
- `reset_count` out 1: single-cycle strobe, coincident with `load_new_c`.
- `show_new_time` out 1: level; display shows entry digits.
- `show_alarm` out 1: level; display shows the alarm time.
- `entry_error` out 1: single-cycle strobe; commit rejected because the entered time is invalid.

## Operation
- States: IDLE, ENTRY, SHOW_ALARM.
- IDLE:
  - Accepted key (`key_valid` and `key` ≤ 9): clear the shift register, shift the key in, clear the timeout counter, go to ENTRY.
  - `alarm_button` high: go to SHOW_ALARM.
- ENTRY:
  - `show_new_time`=1.
  - Accepted key shifts left: ms_hr ← ls_hr, ls_hr ← ms_min, ms_min ← ls_min, ls_min ← key. Clears the timeout counter.
  - Unlimited keys are allowed. The last four digits win, and leading digits stay 0.
  - `time_button`: if the entry is valid, pulse `load_new_c` and `reset_count`; otherwise pulse `entry_error`. Go to IDLE either way.
  - `alarm_button` (with `time_button` low): if valid, pulse `load_new_a`; otherwise pulse `entry_error`. Go to IDLE.
  - Both buttons high in the same cycle: `time_button` takes priority.
  - Button and `key_valid` in the same cycle: the button wins and the key is dropped.
  - `one_second` increments the timeout counter. When the counter reaches `TIMEOUT_S`, go to IDLE with no load and no error. The shift register keeps its value but is not shown.
- SHOW_ALARM:
  - `show_alarm`=1 while `alarm_button` is high.
  - On release, go to IDLE.
  - Keys are ignored.
- Validity: ms_hr ≤ 2; ls_hr ≤ 9; ls_hr ≤ 3 when ms_hr = 2; ms_min ≤ 5; ls_min ≤ 9. So 23:59 is valid and 24:00, 19:60 and 29:00 are invalid.
- Button edges:
  - Buttons are levels. Only the rising edge, detected with a registered copy, triggers a commit.
  - A button already held when ENTRY is entered does not commit until it is released and pressed again.
  - The exception is SHOW_ALARM, which is level-driven.
- Timeout counter: width is $clog2(TIMEOUT_S+1) and it saturates. It is cleared on every state entry.

## Timing
- Reset values:
  - State IDLE.
  - All digit outputs 0.
  - All strobes 0; `show_new_time`=0, `show_alarm`=0; timeout counter 0; button edge registers 0.
- Outputs are registered:
  - A button edge sampled at edge N produces its strobe high during cycle N+1, for exactly one cycle.
  - The state returns to IDLE at the same edge N.
- Digit outputs:
  - Stable during and after the `load_new_*` cycle.
  - Change only on an accepted key.
- An accepted key at edge N is visible on the digit outputs after edge N.
- Timeout: the `one_second` pulse that brings the count to `TIMEOUT_S` moves the state to IDLE at that edge.
- Reset asserted mid-entry: immediate return to the reset values. No strobe may be emitted.

## Structure
- Shared package `alarm_clock_pkg`:
  - State enum `entry_state_t`.
  - `DEFAULT_TIMEOUT_S`=10.
  - Digit limit constants: `MAX_MS_HR`=2, `MAX_LS_HR_AT_2`=3, `MAX_MS_MIN`=5, `MAX_BCD`=9.
- Sub-module `key_shift_reg`: the four-digit shift register with clear and shift enables, plus the validity check as a combinational output.
- FSM, edge detection and timeout live in `time_entry_ctrl`.

## Test plan
- Reset, keys 1,2,3,4, `time_button` rising → digits 1,2,3,4. `load_new_c`=1 and `reset_count`=1 for exactly one cycle, one cycle after the edge. Then IDLE.
- Keys 2,4,0,0, `time_button` → `entry_error` pulse, no `load_new_c`. Keys 2,3,5,9, `alarm_button` → `load_new_a` pulse with digits 2,3,5,9.
- Keys 5, then 12 (ignored), then 1,2,3,0 → digits 1,2,3,0; the last four accepted keys win.
- Key 7, then 10 `one_second` pulses with no key → IDLE, `show_new_time`=0, no strobes. A key after the 9th pulse restarts the count.
- In ENTRY, both buttons rise together with `key_valid` → `load_new_c` only, and the digit is not shifted. In IDLE, hold `alarm_button` → `show_alarm`=1 until release.
- Reset asserted in the cycle after a `time_button` edge → `load_new_c` forced to 0 immediately, all outputs at reset values.
